// File: rtl/alu_issue_ctrl.sv
// Four-state issue sequencer for the ALU: IDLE→READ→EXEC→WB; the result lands in the register file 3 cycles after accept.
// instr_ready only in IDLE (one instruction per 4 cycles); instr_valid outside IDLE is ignored, not queued.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        done,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [15:0] alu_opcode,
    output logic        alu_cin,
    input  logic [15:0] alu_c,
    input  logic [4:0]  alu_flags,
    output logic [4:0]  psr,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_ir;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [15:0] r_alu_opcode;
    logic        r_alu_cin;
    logic [15:0] r_res;
    logic [4:0]  r_flg;
    logic [4:0]  r_psr;
    logic [15:0] r_rf [16];
    logic        w_ready;
    logic        w_done;
    logic        w_wr;
    logic        w_cmp;
    logic [3:0]  w_hi;
    logic [3:0]  w_ext;

    assign w_hi  = r_ir[15:12];
    assign w_ext = r_ir[7:4];

    // Instruction class: w_wr writes Rdest and PSR, w_cmp writes PSR only, neither is a NOP.
    always_comb begin
        w_wr  = 1'b0;
        w_cmp = 1'b0;
        case (w_hi)
            4'h0: begin
                w_wr  = ((w_ext >= 4'h1) && (w_ext <= 4'h9)) || (w_ext == 4'hD);
                w_cmp = (w_ext == 4'hB) || (w_ext == 4'hF);
            end
            4'h5, 4'h6, 4'h7: w_wr = 1'b1;
            4'h8: w_wr = (w_ext == 4'h0) || (w_ext == 4'h4) ||
                         ((w_ext >= 4'h8) && (w_ext <= 4'hB));
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (instr_valid) w_state_nxt = S_READ;
            end
            S_READ: w_state_nxt = S_EXEC;
            S_EXEC: w_state_nxt = S_WB;
            S_WB: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_ir         <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_alu_cin    <= 1'b0;
            r_res        <= '0;
            r_flg        <= '0;
            r_psr        <= '0;
            for (int i = 0; i < 16; i++) r_rf[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: if (instr_valid) r_ir <= instr;
                // Operands go straight into the ALU-facing registers so they are stable for all of EXEC.
                S_READ: begin
                    r_alu_a      <= r_rf[r_ir[11:8]];
                    r_alu_b      <= r_rf[r_ir[3:0]];
                    r_alu_opcode <= r_ir;
                    r_alu_cin    <= r_psr[3];
                end
                S_EXEC: begin
                    r_res <= alu_c;
                    r_flg <= alu_flags;
                end
                S_WB: begin
                    if (w_wr) r_rf[r_ir[11:8]] <= r_res;
                    if (w_wr || w_cmp) r_psr <= r_flg;
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = w_ready;
    assign done        = w_done;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_opcode  = r_alu_opcode;
    assign alu_cin     = r_alu_cin;
    assign psr         = r_psr;
    assign dbg_data    = r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, table vectors, handshake/reset sequences, random stimulus vs a register-array model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        done;
    logic [15:0] alu_a, alu_b, alu_opcode;
    logic        alu_cin;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_rf [16];
    logic [4:0]  m_psr;

    alu_issue_ctrl dut (
        .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .done(done), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_cin(alu_cin), .alu_c(alu_c), .alu_flags(alu_flags),
        .psr(psr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Simple ALU stand-in: returns {Z,C,O,N,L, result}.
    function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] op, input logic cin);
        logic [16:0] s;
        logic [15:0] imm;
        logic        cy, ov, lt, ng;
        cy = 1'b0; ov = 1'b0; lt = 1'b0;
        imm = {8'h00, op[7:0]};
        s = {1'b0, a ^ b};
        if (op[15:12] == 4'h5) begin
            s  = {1'b0, a} + {1'b0, imm};
            cy = s[16];
            ov = (a[15] == imm[15]) && (s[15] != a[15]);
        end else if (op[15:12] == 4'h0 && (op[7:4] == 4'h5 || op[7:4] == 4'h6 || op[7:4] == 4'h7)) begin
            s  = {1'b0, a} + {1'b0, b} + ((op[7:4] == 4'h7) ? 17'(cin) : 17'd0);
            cy = s[16];
            ov = (a[15] == b[15]) && (s[15] != a[15]);
        end else if (op[15:12] == 4'h0 && op[7:4] == 4'h9) begin
            s  = {1'b0, a} + {1'b0, ~b} + 17'd1;
            cy = s[16];
            ov = (a[15] != b[15]) && (s[15] != a[15]);
        end
        ng = s[15];
        if (op[15:12] == 4'h0 && op[7:4] == 4'hB) begin
            s  = {1'b0, a - b};
            ng = $signed(a) < $signed(b);
            lt = a < b;
            return {(a == b), 1'b0, 1'b0, ng, lt, s[15:0]};
        end
        return {(s[15:0] == 16'h0), cy, ov, ng, lt, s[15:0]};
    endfunction

    logic [20:0] alu_res;
    always_comb alu_res = alu_fn(alu_a, alu_b, alu_opcode, alu_cin);
    assign alu_c     = alu_res[15:0];
    assign alu_flags = alu_res[20:16];

    function automatic bit m_writes(input logic [15:0] ins);
        case (ins[15:12])
            4'h0:             return ins[7:4] inside {[4'h1:4'h9], 4'hD};
            4'h5, 4'h6, 4'h7: return 1'b1;
            4'h8:             return ins[7:4] inside {4'h0, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB};
            default:          return 1'b0;
        endcase
    endfunction

    function automatic bit m_compares(input logic [15:0] ins);
        return ins[15:12] == 4'h0 && ins[7:4] inside {4'hB, 4'hF};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reg(input int a, input logic [15:0] e, input string nm);
        dbg_addr = 4'(a);
        #1;
        chk(nm, 32'(dbg_data), 32'(e));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_psr = '0;
    endtask

    // Issue one instruction, check cycle-by-cycle behaviour and update the model.
    task automatic issue(input logic [15:0] ins);
        int          waitc;
        logic [15:0] ea, eb;
        logic        ecin;
        logic [20:0] r;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        waitc = 0;
        while (!instr_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            return;
        end
        ea = m_rf[ins[11:8]];
        eb = m_rf[ins[3:0]];
        ecin = m_psr[3];
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 16'($urandom);
        chk("ready_low_after_accept", 32'(instr_ready), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("done_timing", 32'(done), 32'(k == 3));
            if (k == 2) begin
                chk("exec_alu_a", 32'(alu_a), 32'(ea));
                chk("exec_alu_b", 32'(alu_b), 32'(eb));
                chk("exec_opcode", 32'(alu_opcode), 32'(ins));
                chk("exec_cin", 32'(alu_cin), 32'(ecin));
            end
            if (k == 3) chk("psr_before_wb_edge", 32'(psr), 32'(m_psr));
        end
        r = alu_fn(ea, eb, ins, ecin);
        if (m_writes(ins)) begin
            m_rf[ins[11:8]] = r[15:0];
            m_psr = r[20:16];
        end else if (m_compares(ins)) begin
            m_psr = r[20:16];
        end
        @(negedge clk);
        chk("ready_after_wb", 32'(instr_ready), 32'd1);
        chk("done_after_wb", 32'(done), 32'd0);
        chk("psr_model", 32'(psr), 32'(m_psr));
        chk_reg(int'(ins[11:8]), m_rf[ins[11:8]], "rdest_model");
    endtask

    typedef struct {
        logic [15:0] ins;
        int          addr;
        logic [15:0] exp_dat;
        logic [4:0]  exp_psr;
    } vec_t;

    vec_t tbl [17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          acc_cyc [$];
        int          cyc;
        int          nacc;
        logic [15:0] ins;

        tbl[0]  = '{16'h5105, 1, 16'h0005, 5'b00000};
        tbl[1]  = '{16'h5207, 2, 16'h0007, 5'b00000};
        tbl[2]  = '{16'h0152, 1, 16'h000C, 5'b00000};
        tbl[3]  = '{16'h5401, 4, 16'h0001, 5'b00000};
        tbl[4]  = '{16'h0394, 3, 16'hFFFF, 5'b00010};
        tbl[5]  = '{16'h0364, 3, 16'h0000, 5'b11000};
        tbl[6]  = '{16'h0570, 5, 16'h0001, 5'b00000};
        tbl[7]  = '{16'h5703, 7, 16'h0003, 5'b00000};
        tbl[8]  = '{16'h5805, 8, 16'h0005, 5'b00000};
        tbl[9]  = '{16'h07B8, 7, 16'h0003, 5'b00011};
        tbl[10] = '{16'h0000, 7, 16'h0003, 5'b00011};
        tbl[11] = '{16'h9123, 1, 16'h000C, 5'b00011};
        tbl[12] = '{16'h01F2, 1, 16'h000C, 5'b00000};
        tbl[13] = '{16'h8102, 1, 16'h000B, 5'b00000};
        tbl[14] = '{16'h8112, 1, 16'h000B, 5'b00000};
        tbl[15] = '{16'h01D2, 1, 16'h000C, 5'b00000};
        tbl[16] = '{16'h01A2, 1, 16'h000C, 5'b00000};

        reset_n = 1'b0;
        instr = '0;
        instr_valid = 1'b0;
        dbg_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        chk("reset_ready", 32'(instr_ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_psr", 32'(psr), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("reset_alu_cin", 32'(alu_cin), 32'd0);
        for (int i = 0; i < 16; i++) chk_reg(i, 16'h0000, "reset_rf");

        foreach (tbl[i]) begin
            issue(tbl[i].ins);
            chk_reg(tbl[i].addr, tbl[i].exp_dat, "vec_reg");
            chk("vec_psr", 32'(psr), 32'(tbl[i].exp_psr));
        end
        chk_reg(0, 16'h0000, "r0_untouched");

        // Continuous valid: accepts must be exactly 4 cycles apart.
        @(negedge clk);
        instr = 16'h0000;
        instr_valid = 1'b1;
        for (cyc = 0; cyc < 24; cyc++) begin
            if (instr_ready) acc_cyc.push_back(cyc);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        nacc = acc_cyc.size();
        chk("handshake_accept_count", 32'(nacc), 32'd6);
        for (int i = 1; i < nacc; i++)
            chk("handshake_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
        repeat (4) @(negedge clk);
        chk("handshake_psr", 32'(psr), 32'(m_psr));
        chk_reg(1, m_rf[1], "handshake_r1");

        // Reset during EXEC of ADDI R6,0x10 aborts the instruction.
        @(negedge clk);
        instr = 16'h5610;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_ready", 32'(instr_ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_psr", 32'(psr), 32'd0);
        chk("midrst_alu_b", 32'(alu_b), 32'd0);
        chk_reg(1, 16'h0000, "midrst_r1");
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        chk_reg(6, 16'h0000, "midrst_r6");
        chk("midrst_ready_after", 32'(instr_ready), 32'd1);

        // Random instructions against the model.
        for (int n = 0; n < 60; n++) begin
            ins = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ins[15:12] = 4'h5;
                1: ins[15:12] = 4'h0;
                2: ins[15:12] = 4'h8;
                default: ;
            endcase
            issue(ins);
        end
        for (int i = 0; i < 16; i++) chk_reg(i, m_rf[i], "final_rf");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
